// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
// Contents: NUM_REQ, SEL_W, arb_state_t, sel_t, and sel_to_onehot().
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [SEL_W-1:0] sel_t;

  // Expand a requester index into its one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] sel_to_onehot(input sel_t idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the four requesters and the arbiter.
// Latency: none (wires only).
// Backpressure: a requester holds req high for as long as it needs the line.
// Ports: req (requesters -> arbiter); grant, sel, valid (arbiter -> requesters and mux).
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  sel_t               sel;
  logic               valid;

  modport master (output req, input grant, sel, valid);
  modport slave  (input req, output grant, sel, valid);

endinterface

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set req bit scanning from ptr upwards, mod 4.
// Latency: combinational.
// Backpressure: none.
// Ports: req[3:0], ptr[1:0] in; any (some bit set), winner[1:0] out.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  sel_t               ptr,
  output logic               any,
  output sel_t               winner
);

  sel_t idx;

  // Walk the offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    any    = |req;
    winner = ptr;
    idx    = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + sel_t'(i);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter driving the select of the downstream 4:1 mux.
// Latency: request sampled at edge N, grant/sel/valid visible after edge N.
// Backpressure: the owner keeps the grant while its req stays high; others wait.
// Ports: clk, rst_n (synchronous, active-low); bus (slave modport: req in; grant, sel, valid out).
// Optional build macro ARB_TIMEOUT_EN: limits an owner to HOLD_MAX cycles when others are waiting.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter4_if.slave  bus
);

  // An illegal HOLD_MAX instantiates a module that does not exist, stopping elaboration.
  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_range
    rr_arbiter4_hold_max_out_of_range u_bad_param ();
  end

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  sel_t                sel_q,   sel_d;
  sel_t                ptr_q,   ptr_d;
  logic                pick_any;
  sel_t                pick_win;
  logic                take;

  // ptr always sits one past the last winner, so the current owner is
  // automatically scanned last when re-arbitration happens.
  rr_pick4 u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .winner (pick_win)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             others_req;

  assign others_req = |(bus.req & ~grant_q);
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    take    = 1'b0;

    case (state_q)
      IDLE: begin
        take = pick_any;
      end
      GRANT: begin
        if (!bus.req[sel_q]) begin
          if (pick_any) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt_q == HOLD_LAST && others_req) begin
          take = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    if (take) begin
      state_d = GRANT;
      grant_d = sel_to_onehot(pick_win);
      sel_d   = pick_win;
      ptr_d   = pick_win + sel_t'(1);
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Clears on each new grant, and on expiry when nobody else is waiting.
  always_comb begin
    hold_cnt_d = '0;
    if (!take && state_q == GRANT && hold_cnt_q != HOLD_LAST) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.valid = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arbiter4.sv
// Testbench for rr_arbiter4: directed scenarios plus randomized traffic vs a reference model.
// Latency: outputs are checked 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_rr_arbiter4;

  localparam int HOLD = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  // Reference model: index of current owner (-1 = idle), priority start, last select, hold count.
  int m_owner;
  int m_ptr;
  int m_sel;
  int m_cnt;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_grant(input logic [3:0] r);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (m_ptr + i) % 4;
      if (!found && r[k]) begin
        found   = 1'b1;
        m_owner = k;
        m_sel   = k;
        m_ptr   = (k + 1) % 4;
        m_cnt   = 0;
      end
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic rn);
    if (!rn) begin
      m_owner = -1;
      m_ptr   = 0;
      m_sel   = 0;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      if (r != 4'b0000) model_grant(r);
    end else if (!r[m_owner]) begin
      if (r != 4'b0000) model_grant(r);
      else m_owner = -1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_cnt == HOLD - 1) begin
        if ((r & ~(4'b0001 << m_owner)) != 4'b0000) model_grant(r);
        else m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
`endif
    end
  endtask

  function automatic logic [6:0] model_out();
    logic [3:0] g;
    logic [1:0] s;
    g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    s = m_sel[1:0];
    return {g, s, (m_owner >= 0)};
  endfunction

  // One clock: model sees the same req/rst_n the DUT samples on this edge.
  task automatic tick();
    @(posedge clk);
    model_step(bus.req, rst_n);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    tick();
    tick();
    checks++;
    if ({bus.grant, bus.sel, bus.valid} !== {4'b0000, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold got=%b/%b/%b want=0000/00/0", bus.grant, bus.sel, bus.valid);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus.grant, bus.sel, bus.valid} !== {4'b0001, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL reset_release got=%b/%b/%b want=0001/00/1", bus.grant, bus.sel, bus.valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0100;
    tick();
    checks++;
    if ({bus.grant, bus.sel, bus.valid} !== {4'b0100, 2'b10, 1'b1}) begin
      errors++;
      $display("FAIL single_grant got=%b/%b/%b want=0100/10/1", bus.grant, bus.sel, bus.valid);
    end
    bus.req = 4'b0000;
    tick();
    checks++;
    if ({bus.grant, bus.sel, bus.valid} !== {4'b0000, 2'b10, 1'b0}) begin
      errors++;
      $display("FAIL single_release got=%b/%b/%b want=0000/10/0", bus.grant, bus.sel, bus.valid);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] want;
    do_reset();
    bus.req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      want = 4'b0001 << (k % 4);
      checks++;
      if (bus.grant !== want || bus.valid !== 1'b1) begin
        errors++;
        $display("FAIL rotation_%0d got=%b/%b want=%b/1", k, bus.grant, bus.valid, want);
      end
      if (k < 4) begin
        tick();
        tick();
        checks++;
        if (bus.grant !== want) begin
          errors++;
          $display("FAIL rotation_hold_%0d got=%b want=%b", k, bus.grant, want);
        end
        bus.req = 4'b1111 & ~want;
        tick();
        bus.req = 4'b1111;
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.req = 4'b0001;
    tick();
    checks++;
    if ({bus.grant, bus.sel, bus.valid} !== {4'b0001, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL b2b_first got=%b/%b/%b want=0001/00/1", bus.grant, bus.sel, bus.valid);
    end
    bus.req = 4'b1010;
    tick();
    checks++;
    if ({bus.grant, bus.sel, bus.valid} !== {4'b0010, 2'b01, 1'b1}) begin
      errors++;
      $display("FAIL b2b_skip got=%b/%b/%b want=0010/01/1", bus.grant, bus.sel, bus.valid);
    end
    bus.req = 4'b1000;
    tick();
    checks++;
    if ({bus.grant, bus.sel, bus.valid} !== {4'b1000, 2'b11, 1'b1}) begin
      errors++;
      $display("FAIL b2b_wrap got=%b/%b/%b want=1000/11/1", bus.grant, bus.sel, bus.valid);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.req = 4'b0100;
    tick();
    tick();
    checks++;
    if (bus.grant !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_pre got=%b want=0100", bus.grant);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.grant, bus.sel, bus.valid} !== {4'b0000, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL midrst_drop got=%b/%b/%b want=0000/00/0", bus.grant, bus.sel, bus.valid);
    end
    rst_n   = 1'b1;
    bus.req = 4'b0101;
    tick();
    checks++;
    if ({bus.grant, bus.sel} !== {4'b0001, 2'b00}) begin
      errors++;
      $display("FAIL midrst_regrant got=%b/%b want=0001/00", bus.grant, bus.sel);
    end
    // Pointer must restart at 0: after owning 2 then reset, 1100 must pick 2, not 3.
    do_reset();
    bus.req = 4'b0100;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    bus.req = 4'b1100;
    tick();
    checks++;
    if (bus.grant !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_ptr got=%b want=0100", bus.grant);
    end
  endtask

  task automatic test_hold();
    do_reset();
    bus.req = 4'b0010;
    tick();
`ifdef ARB_TIMEOUT_EN
    bus.req = 4'b0011;
    for (int c = 0; c < HOLD - 1; c++) begin
      tick();
      checks++;
      if (bus.grant !== 4'b0010) begin
        errors++;
        $display("FAIL timeout_hold_%0d got=%b want=0010", c, bus.grant);
      end
    end
    tick();
    checks++;
    if ({bus.grant, bus.sel, bus.valid} !== {4'b0001, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL timeout_switch got=%b/%b/%b want=0001/00/1", bus.grant, bus.sel, bus.valid);
    end
    do_reset();
    bus.req = 4'b0010;
    tick();
    for (int c = 0; c < 3 * HOLD; c++) tick();
    checks++;
    if (bus.grant !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_alone got=%b want=0010", bus.grant);
    end
`else
    bus.req = 4'b0011;
    for (int c = 0; c < 20; c++) tick();
    checks++;
    if ({bus.grant, bus.valid} !== {4'b0010, 1'b1}) begin
      errors++;
      $display("FAIL hold_forever got=%b/%b want=0010/1", bus.grant, bus.valid);
    end
`endif
  endtask

  task automatic test_random();
    logic [6:0] want;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
      rst_n = ($urandom_range(0, 59) != 0);
      tick();
      want = model_out();
      checks++;
      if ({bus.grant, bus.sel, bus.valid} !== want) begin
        errors++;
        $display("FAIL random_c%0d req=%b got=%b/%b/%b want=%b/%b/%b", c, bus.req,
                 bus.grant, bus.sel, bus.valid, want[6:3], want[2:1], want[0]);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    m_owner = -1;
    m_ptr   = 0;
    m_sel   = 0;
    m_cnt   = 0;
    test_reset();
    test_single();
    test_rotation();
    test_back_to_back();
    test_reset_mid_grant();
    test_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Round-robin arbiter that generates the 2-bit select for the team's structural 4:1 mux. It sits directly upstream of that mux.
- Four requesters each raise a request. The block grants exactly one at a time and drives `sel[1:0]` so the mux forwards the granted requester's input bit.
- Grant is held until the owner drops its request, giving fair, starvation-free sharing of one output line.

Parameters:
- `HOLD_MAX`, 16: maximum consecutive grant cycles per owner. Used only when `ARB_TIMEOUT_EN` is defined. Legal range 2..255.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `req`, input, 4: `req[k]` = requester k wants the mux output. Level-sensitive; held while in use.
- `grant`, output, 4: one-hot grant, registered. All-zero when idle.
- `sel`, output, 2: mux select, registered. Equals index of the set `grant` bit; holds last value when idle.
- `valid`, output, 1: 1 when `grant` is non-zero. Mux output is meaningful only when `valid`=1.

Behaviour:
- Reset (`rst_n`=0 at posedge): `grant`=4'b0000, `sel`=2'b00, `valid`=0, priority pointer `ptr`=0, state IDLE, hold counter=0. Reset mid-grant drops the grant on that edge, with no completion.
- States: IDLE, GRANT.
- Arbitration function: winner = first k with `req[k]`=1, scanning `ptr`, `ptr+1`, ... `ptr+3` mod 4.
- IDLE:
  - If `req`≠0 at posedge: grant[winner]=1, `sel`=winner, `valid`=1, `ptr`=(winner+1) mod 4, go to GRANT.
  - Latency: request sampled at edge N, grant visible after edge N.
- GRANT, owner=`sel`:
  - `req[owner]`=1: hold `grant`/`sel`/`ptr` unchanged. Requests from others are ignored.
  - `req[owner]`=0 and others requesting: re-arbitrate on the same edge. The new winner is granted after that edge with no idle bubble; stay in GRANT; update `ptr`.
  - `req[owner]`=0 and `req`=0: `grant`=0, `valid`=0, `sel` unchanged, go to IDLE.
- Wrap-around: `ptr` 3+1 -> 0. Pointer only advances on a new grant.
- Simultaneous requests: resolved purely by `ptr`. With all four held and released in turn, grant order from reset is 0,1,2,3,0.
- `grant` is never multi-hot. `sel` never changes while `valid`=1 except on a re-arbitration edge.

Optional Feature:
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - Counter `hold_cnt` (width `$clog2(HOLD_MAX)`) clears on every new grant and increments each GRANT cycle.
  - When `hold_cnt`=`HOLD_MAX`-1 and any other `req` bit is set, force re-arbitration on that edge even though the owner still requests.
  - The owner has lowest priority (`ptr`=owner+1), so it loses.
  - If no other requester exists, the owner keeps the grant and `hold_cnt` clears.
- Not defined: no counter. Grant is held indefinitely while the owner requests.

Decomposition:
- Package `arb_pkg`:
  - `NUM_REQ`=4 and `SEL_W`=2.
  - Typedef `arb_state_t` enum {IDLE, GRANT}.
  - Typedef `sel_t` logic [`SEL_W`-1:0].
- Sub-module `rr_pick4`: purely combinational. Inputs `req[3:0]` and `ptr[1:0]`; outputs `any` and `winner[1:0]`. It is instantiated once for both the IDLE and re-arbitration paths.

Test Plan:
- Reset: hold `rst_n`=0 with `req`=4'b1111 -> `grant`=0000, `sel`=00, `valid`=0. Release -> after next edge `grant`=0001, `sel`=00.
- Single requester: `req`=0100 from idle -> after 1 edge `grant`=0100, `sel`=10, `valid`=1. Drop `req` -> after 1 edge `valid`=0, `sel` stays 10.
- Fair rotation: `req`=1111, each owner drops its bit for one cycle after 3 cycles, then reasserts -> grant sequence 0001,0010,0100,1000,0001 with no `valid`=0 gap between owners.
- Back-to-back with skip: owner 0, `req`=1010, owner drops -> next grant 0010 (`sel`=01) on the same edge. Then release 1 -> grant 1000 (`sel`=11).
- Reset mid-grant: grant=0100 held, assert `rst_n`=0 one cycle -> `grant`=0000, `ptr`=0. Then `req`=0101 -> grant 0001.
- `ARB_TIMEOUT_EN`, `HOLD_MAX`=4: owner 1 holds, `req`=0011 -> after 4 grant cycles `grant`=0001. Repeat with `req`=0010 only -> `grant` stays 0010 past 4 cycles.
